// File: rtl/ros_meas_pkg.sv
// ros_meas_pkg: shared types, the frame header constant and sizing helpers for the ring-oscillator measurement sequencer.
//   state_t   : sequencer states IDLE..DONE
//   HEADER    : 4-bit frame sync pattern, sent first
//   ch_width  : channel index width, max(1, clog2(n))
//   frame_len : serial frame length in bits
package ros_meas_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LOAD, SHIFT, DONE} state_t;

   localparam logic [3:0] HEADER = 4'b1010;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int frame_len(input int ch_w, input int cnt_w, input int par);
      return 4 + ch_w + cnt_w + par;
   endfunction

endpackage

// File: rtl/ros_frame_shifter.sv
// ros_frame_shifter: parallel-load, MSB-first serializer for one measurement frame.
//   clk, reset : clock and asynchronous active-high reset
//   load       : capture frame_in and restart the bit count
//   shift      : advance one bit
//   frame_in   : frame to send, MSB first
//   data_out   : current bit (MSB of the shift register)
//   last       : the bit on data_out is the final bit of the frame
module ros_frame_shifter #(
   parameter int FRAME_W = 26
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               shift,
   input  logic [FRAME_W-1:0] frame_in,
   output logic               data_out,
   output logic               last
);

   localparam int CW = $clog2(FRAME_W);

   logic [FRAME_W-1:0] sr;
   logic [CW-1:0]      cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= frame_in;
         cnt <= '0;
      end else if (shift) begin
         sr  <= {sr[FRAME_W-2:0], 1'b0};
         cnt <= cnt + 1'b1;
      end
   end

   assign data_out = sr[FRAME_W-1];
   assign last     = (cnt == CW'(FRAME_W - 1));

endmodule

// File: rtl/ros_meas_sequencer.sv
// ros_meas_sequencer: clears the ring-oscillator counters, opens the gate for a programmed time, then streams one or all channel counts as serial frames.
//   clk, reset            : clock and asynchronous active-high reset
//   ena                   : enable; low aborts to IDLE on the next edge
//   start                 : measurement request, honoured in IDLE only
//   gate_cycles           : gate-open length (0 behaves as 1)
//   ch_select             : channel to report when all_channels = 0
//   all_channels          : report channels 0..NUM_CH-1 in order
//   cycle_counts          : packed channel counts, channel k at [k*COUNTER_LENGTH +: COUNTER_LENGTH]
//   gate, ctr_reset, busy : sequencing strobes
//   frame_valid, data_out : serial frame {HEADER, channel, count[, parity]}, MSB first
//   done                  : one-cycle completion pulse
// Build option: define ROS_MEAS_PARITY_EN to append an even-parity bit over channel and count.
module ros_meas_sequencer
   import ros_meas_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int COUNTER_LENGTH = 20,
   parameter int GATE_W         = 16,
   parameter int CLEAR_CYCLES   = 4,
   parameter int SETTLE_CYCLES  = 4,
   localparam int CH_W          = ch_width(NUM_CH)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             ena,
   input  logic                             start,
   input  logic [GATE_W-1:0]                gate_cycles,
   input  logic [CH_W-1:0]                  ch_select,
   input  logic                             all_channels,
   input  logic [NUM_CH*COUNTER_LENGTH-1:0] cycle_counts,
   output logic                             gate,
   output logic                             ctr_reset,
   output logic                             busy,
   output logic                             frame_valid,
   output logic                             data_out,
   output logic                             done
);

`ifdef ROS_MEAS_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   localparam int FW   = frame_len(CH_W, COUNTER_LENGTH, PAR);
   localparam int CS_W = $clog2((CLEAR_CYCLES > SETTLE_CYCLES ? CLEAR_CYCLES : SETTLE_CYCLES) + 1);
   localparam int TW   = (GATE_W > CS_W) ? GATE_W : CS_W;

   localparam logic [TW-1:0]   CLR_LAST = TW'(CLEAR_CYCLES - 1);
   localparam logic [TW-1:0]   SET_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [CH_W:0]   LAST_CH  = (CH_W + 1)'(NUM_CH - 1);

   state_t                    st, nxt;
   logic [TW-1:0]             tmr, gate_last;
   logic [GATE_W-1:0]         gate_q;
   logic [CH_W-1:0]           ch;
   logic                      all_q, more;
   logic [COUNTER_LENGTH-1:0] cnt_sel;
   logic [FW-1:0]             frame;
   logic                      sh_do, sh_last;

   // Timer counts from 0 in each timed state, so the exit compare is against length-1.
   assign gate_last = (gate_q == '0) ? '0 : TW'(gate_q) - TW'(1);
   assign more      = all_q && ({1'b0, ch} < LAST_CH);

   // Indices beyond the last real channel match no k and report a zero count.
   always_comb begin
      cnt_sel = '0;
      for (int k = 0; k < NUM_CH; k++)
         if ({1'b0, ch} == (CH_W + 1)'(k)) cnt_sel = cycle_counts[k*COUNTER_LENGTH +: COUNTER_LENGTH];
   end

`ifdef ROS_MEAS_PARITY_EN
   assign frame = {HEADER, ch, cnt_sel, ^{ch, cnt_sel}};
`else
   assign frame = {HEADER, ch, cnt_sel};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) st <= IDLE;
      else       st <= nxt;
   end

   always_comb begin
      nxt         = st;
      gate        = 1'b0;
      ctr_reset   = 1'b0;
      busy        = (st != IDLE);
      frame_valid = 1'b0;
      done        = 1'b0;
      case (st)
         IDLE:    nxt = start ? CLEAR : IDLE;
         CLEAR:   begin ctr_reset = 1'b1; nxt = (tmr == CLR_LAST) ? GATE : CLEAR; end
         GATE:    begin gate = 1'b1; nxt = (tmr == gate_last) ? SETTLE : GATE; end
         SETTLE:  nxt = (tmr == SET_LAST) ? LOAD : SETTLE;
         LOAD:    nxt = SHIFT;
         SHIFT:   begin frame_valid = 1'b1; nxt = sh_last ? (more ? LOAD : DONE) : SHIFT; end
         DONE:    begin done = 1'b1; nxt = IDLE; end
         default: nxt = IDLE;
      endcase
      if (!ena) nxt = IDLE;
      data_out = frame_valid & sh_do;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmr    <= '0;
         gate_q <= '0;
         ch     <= '0;
         all_q  <= 1'b0;
      end else begin
         tmr <= (nxt != st) ? '0 : tmr + 1'b1;
         if (st == IDLE && ena && start) begin
            gate_q <= gate_cycles;
            ch     <= all_channels ? '0 : ch_select;
            all_q  <= all_channels;
         end else if (st == SHIFT && nxt == LOAD) begin
            ch <= ch + 1'b1;
         end
      end
   end

   ros_frame_shifter #(.FRAME_W(FW)) u_shifter (
      .clk      (clk),
      .reset    (reset),
      .load     (st == LOAD),
      .shift    (st == SHIFT),
      .frame_in (frame),
      .data_out (sh_do),
      .last     (sh_last)
   );

endmodule

// File: tb/tb_ros_meas_sequencer.sv
// tb_ros_meas_sequencer: randomized scoreboard bench for ros_meas_sequencer (default build).
module tb_ros_meas_sequencer;

   localparam int NUM_CH = 4;
   localparam int CL     = 20;
   localparam int CH_W   = 2;
   localparam int F      = 4 + CH_W + CL;

   logic                 clk = 1'b0;
   logic                 reset, ena, start, all_channels;
   logic [15:0]          gate_cycles;
   logic [CH_W-1:0]      ch_select;
   logic [NUM_CH*CL-1:0] cycle_counts;
   logic                 gate, ctr_reset, busy, frame_valid, data_out, done;

   int tests = 0;
   int fails = 0;

   logic [63:0] exp_frames[$];
   int          exp_gate[$];
   int          exp_done = 0;
   bit          mon_en = 1'b0;

   ros_meas_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .ena          (ena),
      .start        (start),
      .gate_cycles  (gate_cycles),
      .ch_select    (ch_select),
      .all_channels (all_channels),
      .cycle_counts (cycle_counts),
      .gate         (gate),
      .ctr_reset    (ctr_reset),
      .busy         (busy),
      .frame_valid  (frame_valid),
      .data_out     (data_out),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Frame as the serial line should carry it: header, channel, count.
   function automatic logic [63:0] mk(input int ch, input logic [CL-1:0] c);
      return (64'hA << (CH_W + CL)) | (64'(ch) << CL) | 64'(c);
   endfunction

   function automatic logic [CL-1:0] count_of(input int k);
      return (k < NUM_CH) ? cycle_counts[k*CL +: CL] : '0;
   endfunction

   // Monitor: measures strobe run lengths and assembles frames, checking against the queues.
   int          crun = 0, grun = 0, nbits = 0, gap = -1;
   logic [63:0] bits = '0;

   always @(negedge clk) begin
      if (!mon_en) begin
         crun = 0; grun = 0; nbits = 0; gap = -1; bits = '0;
      end else begin
         if (ctr_reset) crun++;
         else if (crun > 0) begin
            chk("clear_len", crun, 4);
            crun = 0;
         end
         if (gate) grun++;
         else if (grun > 0) begin
            chk("gate_pending", exp_gate.size() > 0, 1);
            if (exp_gate.size() > 0) chk("gate_len", grun, exp_gate.pop_front());
            grun = 0;
         end
         if (frame_valid) begin
            if (nbits == 0 && gap >= 0) chk("frame_gap", gap, 1);
            bits = {bits[62:0], data_out};
            nbits++;
         end else begin
            chk("dout_idle", data_out, 0);
            if (nbits > 0) begin
               chk("frame_len", nbits, F);
               chk("frame_pending", exp_frames.size() > 0, 1);
               if (exp_frames.size() > 0) chk("frame_bits", bits, exp_frames.pop_front());
               nbits = 0;
               bits  = '0;
               gap   = 0;
            end
            if (gap >= 0) gap++;
         end
         if (done) begin
            chk("done_pending", exp_done > 0, 1);
            chk("done_after_frames", exp_frames.size(), 0);
            if (exp_done > 0) exp_done--;
            gap = -1;
         end
      end
   end

   task automatic pulse_start(input int g, input int c, input bit all);
      @(posedge clk); #1;
      gate_cycles  = 16'(g);
      ch_select    = CH_W'(c);
      all_channels = all;
      start        = 1'b1;
      @(posedge clk); #1;
      start        = 1'b0;
   endtask

   // One full measurement: queue the expected response, then stir inputs while busy.
   task automatic run_seq(input int g, input int c, input bit all);
      int n;
      exp_gate.push_back(g == 0 ? 1 : g);
      if (all) for (int k = 0; k < NUM_CH; k++) exp_frames.push_back(mk(k, count_of(k)));
      else exp_frames.push_back(mk(c, count_of(c)));
      exp_done++;
      pulse_start(g, c, all);
      gate_cycles  = 16'($urandom);
      ch_select    = CH_W'($urandom);
      all_channels = 1'($urandom);
      n = 0;
      while (busy && n < 3000) begin
         if ($urandom_range(0, 3) == 0) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         n++;
      end
      chk("seq_timeout", n < 3000, 1);
      chk("queues_empty", exp_frames.size() + exp_gate.size() + exp_done, 0);
      repeat (3) @(posedge clk);
      #1 chk("idle_after", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, dn;
      reset = 1'b1; ena = 1'b1; start = 1'b0; all_channels = 1'b0;
      gate_cycles = '0; ch_select = '0; cycle_counts = '0;
      #12;
      chk("rst_gate", gate, 0);
      chk("rst_ctr_reset", ctr_reset, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_valid", frame_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_done", done, 0);
      @(posedge clk); #1 reset = 1'b0;
      mon_en = 1'b1;

      for (int k = 0; k < NUM_CH; k++) cycle_counts[k*CL +: CL] = CL'($urandom);
      cycle_counts[2*CL +: CL] = 20'h12345;
      run_seq(10, 2, 1'b0);

      for (int k = 0; k < NUM_CH; k++) cycle_counts[k*CL +: CL] = CL'(k + 1);
      run_seq(7, 0, 1'b1);

      run_seq(0, 1, 1'b0);

      for (int i = 0; i < 15; i++) begin
         for (int k = 0; k < NUM_CH; k++) cycle_counts[k*CL +: CL] = CL'($urandom);
         run_seq($urandom_range(0, 12), $urandom_range(0, NUM_CH - 1), ($urandom_range(0, 2) == 0));
      end

      // Drop ena while bit 7 of the frame is on the line.
      mon_en = 1'b0;
      pulse_start(3, 1, 1'b0);
      n = 0;
      while (!frame_valid && n < 500) begin @(posedge clk); #1; n++; end
      chk("abort_reach_shift", n < 500, 1);
      repeat (7) @(posedge clk);
      #1 ena = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", busy, 0);
      chk("abort_frame_valid", frame_valid, 0);
      chk("abort_data_out", data_out, 0);
      chk("abort_gate", gate, 0);
      ena = 1'b1;
      dn = 0;
      for (int i = 0; i < 60; i++) begin @(negedge clk); if (done || busy) dn++; end
      chk("abort_no_done", dn, 0);

      // Async reset between edges while the gate is open.
      pulse_start(20, 3, 1'b0);
      n = 0;
      while (!gate && n < 500) begin @(posedge clk); #1; n++; end
      chk("rst_reach_gate", n < 500, 1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_gate", gate, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ctr_reset", ctr_reset, 0);
      @(posedge clk); #1 reset = 1'b0;
      mon_en = 1'b1;
      cycle_counts[3*CL +: CL] = 20'hABCDE;
      run_seq(5, 3, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ros_meas_sequencer.md
ROS_MEAS_SEQUENCER -- requirements
Module: ros_meas_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of ring-oscillator counter channels (2..16).
REQ-002 SHALL have parameter COUNTER_LENGTH, default 20, width of each channel count.
REQ-003 SHALL have parameter GATE_W, default 16, width of the gate-length operand.
REQ-004 SHALL have parameters CLEAR_CYCLES, default 4, and SETTLE_CYCLES, default 4: counter-clear and post-gate settle lengths in clk cycles.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port ena, input, 1, design enable.
REQ-008 SHALL have port start, input, 1, measurement request, sampled in IDLE only.
REQ-009 SHALL have port gate_cycles, input, GATE_W, gate-open length in clk cycles.
REQ-010 SHALL have port ch_select, input, CH_W = max(1,clog2(NUM_CH)), single-channel selector.
REQ-011 SHALL have port all_channels, input, 1, 1 = stream every channel 0..NUM_CH-1 in order.
REQ-012 SHALL have port cycle_counts, input, NUM_CH*COUNTER_LENGTH, channel k at bits [k*COUNTER_LENGTH +: COUNTER_LENGTH].
REQ-013 SHALL have outputs gate (1), ctr_reset (1), busy (1), frame_valid (1), data_out (1), done (1).

Function
REQ-014 SHALL implement states IDLE, CLEAR, GATE, SETTLE, LOAD, SHIFT, DONE.
REQ-015 SHALL, in IDLE with ena=1 and start=1, capture gate_cycles, ch_select, all_channels and enter CLEAR next cycle; start in other states is ignored.
REQ-016 SHALL hold ctr_reset=1 for exactly CLEAR_CYCLES cycles in CLEAR, then enter GATE.
REQ-017 SHALL hold gate=1 for exactly captured gate_cycles cycles in GATE; gate_cycles=0 is treated as 1.
REQ-018 SHALL hold gate=0 for SETTLE_CYCLES cycles in SETTLE, then enter LOAD.
REQ-019 SHALL, in LOAD (one cycle), load frame {4'b1010, channel index (CH_W), count (COUNTER_LENGTH)}; channel = captured ch_select, or 0 when all_channels=1.
REQ-020 SHALL load count field all-zero when the channel index is >= NUM_CH.
REQ-021 SHALL, in SHIFT, drive data_out MSB-first, one bit per cycle, with frame_valid=1 for exactly F cycles, F = 4+CH_W+COUNTER_LENGTH (+1 with parity).
REQ-022 SHALL, after the last bit, return to LOAD with channel+1 if all_channels=1 and channel < NUM_CH-1, else enter DONE; frames are back-to-back with one LOAD gap cycle.
REQ-023 SHALL pulse done=1 for one cycle in DONE, then return to IDLE.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL drive data_out=0 whenever frame_valid=0.
REQ-026 SHALL, on ena=0 in any state, abort to IDLE on the next edge, deasserting gate, ctr_reset, frame_valid, busy, no done pulse.

Reset
REQ-027 SHALL, while reset=1, force state IDLE and gate, ctr_reset, busy, frame_valid, data_out, done = 0, shift register and counters = 0, independent of clk.
REQ-028 SHALL, on reset asserted mid-frame, discard the frame; the first post-reset start begins a full new sequence.

Configuration
REQ-029 SHALL, with macro ROS_MEAS_PARITY_EN defined, append one even-parity bit over channel index and count as the final frame bit.
REQ-030 SHALL, without ROS_MEAS_PARITY_EN, omit the parity bit, F = 4+CH_W+COUNTER_LENGTH.

Structure
REQ-031 SHALL place the state enum typedef, HEADER constant 4'b1010 and CH_W/frame-length functions in package ros_meas_pkg.
REQ-032 SHALL implement the load/shift datapath as sub-module ros_frame_shifter (load, shift, data_out, last-bit flag).

Verification
REQ-033 Defaults, gate_cycles=10, ch_select=2, count2=0x12345, start -> ctr_reset 4 cycles, gate 10 cycles, frame bits 1010_10_0001_0010_0011_0100_0101, done 1 cycle.
REQ-034 all_channels=1, counts 1,2,3,4 -> four frames, channel fields 00..11, one-cycle gaps, single done after frame 3.
REQ-035 gate_cycles=0 -> gate high exactly 1 cycle; start during GATE -> ignored, no second sequence.
REQ-036 ena dropped on bit 7 of SHIFT -> next edge busy=0, frame_valid=0, data_out=0, no done.
REQ-037 reset asserted between edges during GATE -> gate=0 immediately; new start yields full correct frame.
REQ-038 ROS_MEAS_PARITY_EN, count=0x00001, channel 0 -> 27-bit frame ending with parity bit 1.
